network_batch_ctrl: RTL and testbench
=====================================

# network_batch_ctrl

Batch sequencer that sits around `run_network` and drives both its inputs and its output. It buffers up to DEPTH binary pixel vectors written from the JTAG side. On `go`, it presents each buffered vector to `run_network` in order, pulses `start`, and waits the fixed run length. It then samples the two-bit verdict and accumulates per-batch class counts and a per-sample result vector for readback.

## Interface
Parameters:
- HEIGHT, 7, pixel vector width; must match `run_network` HEIGHT
- DEPTH, 16, sample buffer entries (power of two, ≥2)
- RUN_CYCLES, 7168, network run length in clk cycles, equal to HEIGHT·2^(WIDTH+2) for WIDTH=8

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  sample write request
- wr_pixels  in  HEIGHT  sample to buffer
- wr_ready  out  1  buffer accepts a write this cycle
- go  in  1  start a batch over all buffered samples
- pixels  out  HEIGHT  vector presented to `run_network`
- start  out  1  one-cycle start pulse to `run_network`
- neuron_out  in  2  `run_network` verdict: 01 = pos, 10 = neg, 00/11 = unknown
- busy  out  1  batch in progress
- done  out  1  one-cycle pulse at batch completion
- pos_count, neg_count, unk_count  out  $clog2(DEPTH+1)  per-batch tallies
- result_bits  out  DEPTH  bit i = 1 iff the i-th sample of the batch was classified pos

## Operation
- Sample buffer is a FIFO of DEPTH×HEIGHT with a fill count of $clog2(DEPTH+1) bits. Read and write pointers wrap modulo DEPTH.
- wr_ready = !busy && fill < DEPTH. A write occurs when wr_valid && wr_ready. wr_valid while full or busy is dropped silently.
- FSM states: IDLE, START, WAIT, SAMPLE, DONE.
  - IDLE: on go, clear all counts and result_bits, then go to START. If fill = 0 (after any same-cycle write), go to DONE instead.
  - START: start = 1 for exactly this cycle. Load wait counter = RUN_CYCLES+1. Go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, go to SAMPLE.
  - SAMPLE: classify neuron_out.
    - 01: increment pos_count and set result_bits[idx].
    - 10: increment neg_count.
    - 00 or 11: increment unk_count.
    - Then pop the FIFO and increment idx. Go to START if the FIFO is non-empty after the pop, else DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- go with wr_valid in the same IDLE cycle: the write is accepted and belongs to the batch.
- go outside IDLE is ignored.
- pixels = FIFO head (registered) from the START cycle through SAMPLE, held stable for the whole run. In IDLE it holds its last value, or 0 after reset.
- busy = 1 in START, WAIT, SAMPLE and DONE.
- Counts and result_bits hold their values after DONE until the next go or rst. Unused result_bits stay 0.
- Counter widths: pos+neg+unk = samples processed ≤ DEPTH, so no saturation is needed.

## Timing
- Reset values: wr_ready = 1, start = 0, busy = 0, done = 0, pixels = 0, all counts = 0, result_bits = 0, FIFO empty, state IDLE.
- go accepted at cycle 0 → START (start = 1) at cycle 1.
- Verdict sampled at cycle 1 + RUN_CYCLES + 2, i.e. RUN_CYCLES+1 cycles after `run_network` leaves reset. This is after its iteration counter expires, so `neuron_out[1]` is valid.
- Per-sample period: RUN_CYCLES + 3 cycles (START, RUN_CYCLES+1 WAIT cycles, SAMPLE).
- The next start pulse follows SAMPLE immediately.
- Batch of N samples: done asserts at cycle 1 + N·(RUN_CYCLES+3). busy falls the cycle after done.
- Empty-buffer go: done at cycle 1, counts 0.
- rst mid-batch: next cycle is IDLE with all outputs at reset values. The FIFO is flushed, and no done pulse is produced.
- wr_ready falls in the cycle after go is accepted. It rises the cycle after DONE.

## Test plan
- Bench: RUN_CYCLES = 16 with a behavioural `run_network` model.
- Reset, then write 3 samples 7'h7F, 7'h00, 7'h7F; model returns pos for 7'h7F and neg for 7'h00; go → pos_count = 2, neg_count = 1, unk_count = 0, result_bits = 16'h0005, done at cycle 1 + 3·19 = 58.
- Fill 16 samples, then assert wr_valid again → wr_ready = 0 and fill stays 16. Run the batch and check exactly 16 start pulses, each 19 cycles apart, with pixels stable between pulses.
- go with an empty buffer → done pulse at cycle 1, all counts 0, no start pulse.
- Model drives 00 and then 11 for two samples → unk_count = 2, result_bits = 0.
- Assert rst at cycle 30 of a 3-sample batch → busy = 0, start = 0, counts 0, wr_ready = 1 the next cycle; a subsequent go with no writes gives immediate done with zero counts.
- Same-cycle go and wr_valid in IDLE with 1 buffered sample → 2 samples processed. wr_valid during busy is ignored and is not present in the next batch.

Source files
------------

// File: rtl/network_batch_ctrl_if.sv
// Sample write channel of network_batch_ctrl.
//   wr_valid   host -> ctrl  sample write request
//   wr_pixels  host -> ctrl  HEIGHT-bit pixel vector to buffer
//   wr_ready   ctrl -> host  buffer accepts a write this cycle
interface network_batch_ctrl_if #(
    parameter int HEIGHT = 7
) ();
    logic              wr_valid;
    logic [HEIGHT-1:0] wr_pixels;
    logic              wr_ready;

    modport master (output wr_valid, output wr_pixels, input wr_ready);
    modport slave  (input wr_valid, input wr_pixels, output wr_ready);
endinterface

// File: rtl/network_batch_ctrl.sv
// Batch sequencer around run_network. Buffers up to DEPTH pixel vectors,
// then on go presents each one to run_network, pulses start, waits the
// fixed run length, samples the 2-bit verdict and tallies the results.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   wr           sample write channel (slave modport)
//   go           start a batch over all buffered samples
//   pixels       registered FIFO head presented to run_network
//   start        one-cycle start pulse to run_network
//   neuron_out   verdict: 01 pos, 10 neg, 00/11 unknown
//   busy, done   batch in progress / one-cycle completion pulse
//   pos_count, neg_count, unk_count, result_bits   per-batch results
module network_batch_ctrl #(
    parameter int HEIGHT     = 7,
    parameter int DEPTH      = 16,
    parameter int RUN_CYCLES = 7168
) (
    input  logic                         clk,
    input  logic                         rst,
    network_batch_ctrl_if.slave          wr,
    input  logic                         go,
    output logic [HEIGHT-1:0]            pixels,
    output logic                         start,
    input  logic [1:0]                   neuron_out,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   pos_count,
    output logic [$clog2(DEPTH+1)-1:0]   neg_count,
    output logic [$clog2(DEPTH+1)-1:0]   unk_count,
    output logic [DEPTH-1:0]             result_bits
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(RUN_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT, S_SAMPLE, S_DONE
    } state_t;

    state_t state, state_next;

    logic [HEIGHT-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_inc, idx;
    logic [CW-1:0]     fill;
    logic [WW-1:0]     wait_cnt;
    logic              wr_fire, pop, clear;

    assign busy        = (state != S_IDLE);
    assign wr.wr_ready = !busy && (fill < CW'(DEPTH));
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign rd_ptr_inc  = rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        done       = 1'b0;
        clear      = 1'b0;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    clear = 1'b1;
                    // a same-cycle write counts toward the batch
                    state_next = (fill == '0 && !wr_fire) ? S_DONE : S_START;
                end
            end
            S_START: begin
                start      = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == WW'(1)) state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                pop        = 1'b1;
                state_next = (fill == CW'(1)) ? S_DONE : S_START;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr.wr_pixels;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            idx         <= '0;
            wait_cnt    <= '0;
            pixels      <= '0;
            pos_count   <= '0;
            neg_count   <= '0;
            unk_count   <= '0;
            result_bits <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr_inc;
            fill <= fill + CW'(wr_fire) - CW'(pop);

            // Load the head one cycle ahead so it is stable from START on.
            // From IDLE with an empty buffer the head is the same-cycle write;
            // from SAMPLE it is the entry behind the one being popped.
            if (state_next == S_START) begin
                if (state == S_SAMPLE)  pixels <= mem[rd_ptr_inc];
                else if (fill == '0)    pixels <= wr.wr_pixels;
                else                    pixels <= mem[rd_ptr];
            end

            if (state == S_START)     wait_cnt <= WW'(RUN_CYCLES + 1);
            else if (state == S_WAIT) wait_cnt <= wait_cnt - WW'(1);

            if (clear) begin
                pos_count   <= '0;
                neg_count   <= '0;
                unk_count   <= '0;
                result_bits <= '0;
                idx         <= '0;
            end else if (state == S_SAMPLE) begin
                case (neuron_out)
                    2'b01: begin
                        pos_count        <= pos_count + CW'(1);
                        result_bits[idx] <= 1'b1;
                    end
                    2'b10:   neg_count <= neg_count + CW'(1);
                    default: unk_count <= unk_count + CW'(1);
                endcase
                idx <= idx + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_network_batch_ctrl.sv
module tb_network_batch_ctrl;
    localparam int HEIGHT = 7;
    localparam int DEPTH  = 16;
    localparam int RUN    = 16;
    localparam int PERIOD = RUN + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [6:0]  pixels;
    logic        start;
    logic [1:0]  neuron_out;
    logic        busy, done;
    logic [4:0]  pos_count, neg_count, unk_count;
    logic [15:0] result_bits;

    network_batch_ctrl_if #(.HEIGHT(HEIGHT)) wr_if ();

    network_batch_ctrl #(.HEIGHT(HEIGHT), .DEPTH(DEPTH), .RUN_CYCLES(RUN)) dut (
        .clk(clk), .rst(rst), .wr(wr_if.slave), .go(go), .pixels(pixels),
        .start(start), .neuron_out(neuron_out), .busy(busy), .done(done),
        .pos_count(pos_count), .neg_count(neg_count), .unk_count(unk_count),
        .result_bits(result_bits)
    );

    always #5 clk = ~clk;

    // Behavioural run_network: verdict valid RUN+1 cycles after start,
    // garbage (11) before that.
    int run_cnt = 0;
    always_ff @(posedge clk) begin
        if (start)              run_cnt <= 0;
        else if (run_cnt < 1000) run_cnt <= run_cnt + 1;
    end

    function automatic logic [1:0] verdict(input logic [6:0] p);
        case (p)
            7'h7F:   return 2'b01;
            7'h00:   return 2'b10;
            7'h55:   return 2'b00;
            7'h2A:   return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    assign neuron_out = (run_cnt >= RUN + 1) ? verdict(pixels) : 2'b11;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         nstart, bad_gap, unstable;
    logic [6:0] sp [32];

    task automatic write_sample(input logic [6:0] px);
        wr_if.wr_valid  = 1'b1;
        wr_if.wr_pixels = px;
        tick();
        wr_if.wr_valid  = 1'b0;
    endtask

    // go in cycle 0; monitors start pulses, pixel stability and done cycle
    task automatic run_batch(input bit go_wr, input logic [6:0] go_px,
                             input bit busy_wr, output int done_cyc);
        int         cyc, last_start;
        logic [6:0] held;
        nstart = 0; bad_gap = 0; unstable = 0;
        last_start = -1; done_cyc = -1; held = '0;
        go = 1'b1;
        wr_if.wr_valid  = go_wr;
        wr_if.wr_pixels = go_px;
        tick();
        go = 1'b0;
        wr_if.wr_valid  = busy_wr;
        wr_if.wr_pixels = 7'h7F;
        cyc = 1;
        check("ready_low_busy", {31'b0, wr_if.wr_ready}, 32'd0);
        while (cyc < 2000) begin
            if (start) begin
                if (last_start >= 0 && cyc - last_start != PERIOD) bad_gap++;
                if (nstart < 32) sp[nstart] = pixels;
                nstart++;
                last_start = cyc;
                held = pixels;
            end else if (busy && !done && last_start >= 0 && pixels !== held) begin
                unstable++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        wr_if.wr_valid = 1'b0;
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
        tick();
        check("busy_after_done", {31'b0, busy}, 32'd0);
        check("ready_after_done", {31'b0, wr_if.wr_ready}, 32'd1);
    endtask

    task automatic check_counts(input string tag, input int p, input int n,
                                input int u, input logic [15:0] rb);
        check({tag, "_pos"}, {27'b0, pos_count}, p);
        check({tag, "_neg"}, {27'b0, neg_count}, n);
        check({tag, "_unk"}, {27'b0, unk_count}, u);
        check({tag, "_bits"}, {16'b0, result_bits}, {16'b0, rb});
    endtask

    int d;

    initial begin
        rst = 1'b1; go = 1'b0;
        wr_if.wr_valid = 1'b0; wr_if.wr_pixels = '0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        check("rst_ready",  {31'b0, wr_if.wr_ready}, 32'd1);
        check("rst_start",  {31'b0, start}, 32'd0);
        check("rst_busy",   {31'b0, busy},  32'd0);
        check("rst_done",   {31'b0, done},  32'd0);
        check("rst_pixels", {25'b0, pixels}, 32'd0);
        check_counts("rst", 0, 0, 0, 16'h0000);

        // three-sample batch
        write_sample(7'h7F); write_sample(7'h00); write_sample(7'h7F);
        run_batch(0, 7'h00, 0, d);
        check("b3_done_cyc", d, 1 + 3 * PERIOD);
        check("b3_starts", nstart, 3);
        check("b3_px1", {25'b0, sp[1]}, 32'h00);
        check("b3_px2", {25'b0, sp[2]}, 32'h7F);
        check_counts("b3", 2, 1, 0, 16'h0005);

        // fill to capacity, extra write dropped
        for (int i = 0; i < DEPTH; i++) write_sample((i % 2 == 0) ? 7'h7F : 7'h00);
        wr_if.wr_valid  = 1'b1;
        wr_if.wr_pixels = 7'h55;
        check("full_ready", {31'b0, wr_if.wr_ready}, 32'd0);
        tick();
        wr_if.wr_valid = 1'b0;
        run_batch(0, 7'h00, 0, d);
        check("full_done_cyc", d, 1 + DEPTH * PERIOD);
        check("full_starts", nstart, DEPTH);
        check("full_gap", bad_gap, 0);
        check("full_stable", unstable, 0);
        check("full_px0", {25'b0, sp[0]}, 32'h7F);
        check("full_px15", {25'b0, sp[15]}, 32'h00);
        check_counts("full", 8, 8, 0, 16'h5555);

        // empty-buffer go
        run_batch(0, 7'h00, 0, d);
        check("empty_done_cyc", d, 1);
        check("empty_starts", nstart, 0);
        check_counts("empty", 0, 0, 0, 16'h0000);

        // unknown verdicts 00 and 11
        write_sample(7'h55); write_sample(7'h2A);
        run_batch(0, 7'h00, 0, d);
        check("unk_done_cyc", d, 1 + 2 * PERIOD);
        check_counts("unk", 0, 0, 2, 16'h0000);

        // reset in the middle of a batch (after the first verdict)
        write_sample(7'h7F); write_sample(7'h00); write_sample(7'h7F);
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 1; c < 30; c++) tick();
        check("mid_pos_before_rst", {27'b0, pos_count}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy",  {31'b0, busy},  32'd0);
        check("mid_start", {31'b0, start}, 32'd0);
        check("mid_done",  {31'b0, done},  32'd0);
        check("mid_ready", {31'b0, wr_if.wr_ready}, 32'd1);
        check("mid_pixels", {25'b0, pixels}, 32'd0);
        check_counts("mid", 0, 0, 0, 16'h0000);
        run_batch(0, 7'h00, 0, d);
        check("flush_done_cyc", d, 1);
        check("flush_starts", nstart, 0);
        check_counts("flush", 0, 0, 0, 16'h0000);

        // same-cycle go and write, writes during busy dropped
        write_sample(7'h7F);
        run_batch(1, 7'h00, 1, d);
        check("same_done_cyc", d, 1 + 2 * PERIOD);
        check("same_starts", nstart, 2);
        check("same_px1", {25'b0, sp[1]}, 32'h00);
        check_counts("same", 1, 1, 0, 16'h0001);
        run_batch(0, 7'h00, 0, d);
        check("after_busy_done_cyc", d, 1);
        check("after_busy_starts", nstart, 0);
        check_counts("after_busy", 0, 0, 0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
